cd_host_regs: RTL and testbench

- A-bus responder that models the CD block host-interface register file at A-bus 0x25890000–0x2589003F, selected through ACS2_N.
- SCU is the initiator. This block decodes its reads and writes and holds HIRQ, HIRQMASK and CR1–CR4.
- Runs a command handshake: the host writes CR1–CR4, the block goes busy and loads a response. When idle it emits periodic status reports.
- Drives the A-bus interrupt request (AIRQ_N).

---
 rtl/cd_host_regs.sv | 223 ++++++++++++++++++++++
 tb/tb_cd_host_regs.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cd_host_regs.sv
// +----------------------------------------------------------------------------+
// | cd_host_regs: CD block host-interface register file on the A-bus (ACS2_N)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cd_host_regs #(
  parameter int          CMD_LAT = 16,
  parameter int          PERIOD  = 1024,
  parameter logic [7:0]  STATUS  = 8'h01
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic [25:1] A,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WRL_N,
  input  logic        WRU_N,
  output logic        IRQ_N,
  output logic        BUSY
);

  localparam int CNT_MAX = (PERIOD > CMD_LAT) ? PERIOD : CMD_LAT;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CMD_LOAD    = CW'(CMD_LAT - 1);

  localparam logic [15:0] OFF_HIRQ = 16'h0008;
  localparam logic [15:0] OFF_MASK = 16'h000C;
  localparam logic [15:0] OFF_CR1  = 16'h0018;
  localparam logic [15:0] OFF_CR2  = 16'h001C;
  localparam logic [15:0] OFF_CR3  = 16'h0020;
  localparam logic [15:0] OFF_CR4  = 16'h0024;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   hirq_q, hirq_d;
  logic [15:0]   mask_q, mask_d;
  logic [15:0]   cr1_q, cr1_d, cr2_q, cr2_d, cr3_q, cr3_d, cr4_q, cr4_d;
  logic          busy_q, busy_d;
  logic          irq_n_q, irq_n_d;
  logic          resp_pend_q, resp_pend_d;
  logic          wr_idle_q, wr_idle_d;
  logic          rd_idle_q, rd_idle_d;

  logic          sel;
  logic [15:0]   off;
  logic [15:0]   be;
  logic          wr_ev;
  logic          rd_cr4_ev;
  logic          cmd_start;

  function automatic logic [15:0] merge(input logic [15:0] old_v,
                                        input logic [15:0] new_v,
                                        input logic [15:0] mask_v);
    return (old_v & ~mask_v) | (new_v & mask_v);
  endfunction

  assign sel       = !CS_N && (A[25:16] == 10'h189);
  assign off       = {A[15:1], 1'b0};
  assign be        = {{8{~WRU_N}}, {8{~WRL_N}}};
  assign wr_ev     = sel && (be != 16'h0000) && wr_idle_q;
  assign rd_cr4_ev = sel && !RD_N && rd_idle_q && (off == OFF_CR4);
  assign cmd_start = wr_ev && (off == OFF_CR4) && (state_q == S_IDLE);

  always_comb begin
    DO = 16'h0000;
    if (sel && !RD_N) begin
      case (off)
        OFF_HIRQ: DO = hirq_q;
        OFF_MASK: DO = mask_q;
        OFF_CR1:  DO = cr1_q;
        OFF_CR2:  DO = cr2_q;
        OFF_CR3:  DO = cr3_q;
        OFF_CR4:  DO = cr4_q;
        default:  DO = 16'h0000;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hirq_d      = hirq_q;
    mask_d      = mask_q;
    cr1_d       = cr1_q;
    cr2_d       = cr2_q;
    cr3_d       = cr3_q;
    cr4_d       = cr4_q;
    busy_d      = busy_q;
    irq_n_d     = irq_n_q;
    resp_pend_d = resp_pend_q;
    wr_idle_d   = wr_idle_q;
    rd_idle_d   = rd_idle_q;

    if (CE_R) begin
      wr_idle_d = WRL_N & WRU_N;
      rd_idle_d = RD_N;
      irq_n_d   = ~|(hirq_q & mask_q);

      // Host writes first so that internal loads below take priority.
      if (wr_ev) begin
        case (off)
          OFF_HIRQ: hirq_d = hirq_q & (DI | ~be);
          OFF_MASK: mask_d = merge(mask_q, DI, be);
          OFF_CR1:  if (!busy_q) cr1_d = merge(cr1_q, DI, be);
          OFF_CR2:  if (!busy_q) cr2_d = merge(cr2_q, DI, be);
          OFF_CR3:  if (!busy_q) cr3_d = merge(cr3_q, DI, be);
          OFF_CR4: begin
            if (cmd_start) begin
              cr4_d     = merge(cr4_q, DI, be);
              hirq_d[0] = 1'b0;
              busy_d    = 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (rd_cr4_ev) resp_pend_d = 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cnt_q == PERIOD_LAST) begin
            cnt_d = '0;
            if (!resp_pend_q) begin
              cr1_d = {STATUS | 8'h20, 8'h00};
              cr2_d = 16'h0000;
              cr3_d = 16'h0000;
              cr4_d = 16'h0000;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          if (cmd_start) begin
            state_d = S_CMD;
            cnt_d   = CMD_LOAD;
          end
        end
        S_CMD: begin
          if (cnt_q == '0) state_d = S_RESP;
          else             cnt_d   = cnt_q - CW'(1);
        end
        S_RESP: begin
          case (cr1_q[15:8])
            8'h00: begin
              cr1_d = {STATUS, 8'h00};
              cr2_d = 16'h0000;
              cr3_d = 16'h0000;
              cr4_d = 16'h0000;
            end
            8'h01: begin
              cr1_d = {STATUS, 8'h00};
              cr2_d = 16'h0201;
              cr3_d = 16'h0000;
              cr4_d = 16'h0400;
            end
            default: begin
              cr1_d = 16'hFF00;
              cr2_d = 16'h0000;
              cr3_d = 16'h0000;
              cr4_d = 16'h0000;
            end
          endcase
          hirq_d[0]   = 1'b1;
          resp_pend_d = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hirq_q      <= 16'h0001;
      mask_q      <= 16'h0000;
      cr1_q       <= 16'h0043;
      cr2_q       <= 16'h4442;
      cr3_q       <= 16'h4C4F;
      cr4_q       <= 16'h434B;
      busy_q      <= 1'b0;
      irq_n_q     <= 1'b1;
      resp_pend_q <= 1'b0;
      wr_idle_q   <= 1'b1;
      rd_idle_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hirq_q      <= hirq_d;
      mask_q      <= mask_d;
      cr1_q       <= cr1_d;
      cr2_q       <= cr2_d;
      cr3_q       <= cr3_d;
      cr4_q       <= cr4_d;
      busy_q      <= busy_d;
      irq_n_q     <= irq_n_d;
      resp_pend_q <= resp_pend_d;
      wr_idle_q   <= wr_idle_d;
      rd_idle_q   <= rd_idle_d;
    end
  end

  assign IRQ_N = irq_n_q;
  assign BUSY  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cd_host_regs.sv
// +----------------------------------------------------------------------------+
// | tb_cd_host_regs: directed bench for cd_host_regs (CMD_LAT=4, PERIOD=16)    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cd_host_regs;

  localparam int CMD_LAT = 4;
  localparam int PERIOD  = 16;

  localparam logic [15:0] HIRQ = 16'h0008;
  localparam logic [15:0] MASK = 16'h000C;
  localparam logic [15:0] CR1  = 16'h0018;
  localparam logic [15:0] CR2  = 16'h001C;
  localparam logic [15:0] CR3  = 16'h0020;
  localparam logic [15:0] CR4  = 16'h0024;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE_R = 1'b1;
  logic [25:1] A = '0;
  logic [15:0] DI = '0;
  logic [15:0] DO;
  logic        CS_N = 1'b1;
  logic        RD_N = 1'b1;
  logic        WRL_N = 1'b1;
  logic        WRU_N = 1'b1;
  logic        IRQ_N;
  logic        BUSY;

  int n_chk  = 0;
  int n_fail = 0;

  cd_host_regs #(.CMD_LAT(CMD_LAT), .PERIOD(PERIOD), .STATUS(8'h01)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .A(A), .DI(DI), .DO(DO),
    .CS_N(CS_N), .RD_N(RD_N), .WRL_N(WRL_N), .WRU_N(WRU_N),
    .IRQ_N(IRQ_N), .BUSY(BUSY)
  );

  always #50 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Zero-tick read between clock edges: no posedge sees RD_N low.
  task automatic peek(input logic [15:0] off, output logic [15:0] d);
    A = {10'h189, off[15:1]}; CS_N = 1'b0; RD_N = 1'b0;
    #1 d = DO;
    CS_N = 1'b1; RD_N = 1'b1;
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [15:0] off, input logic [15:0] exp);
    logic [15:0] d;
    peek(off, d);
    chk(tag, d, exp);
  endtask

  task automatic wr(input logic [15:0] off, input logic [15:0] data,
                    input logic wl = 1'b1, input logic wu = 1'b1);
    @(negedge CLK);
    A = {10'h189, off[15:1]}; DI = data; CS_N = 1'b0;
    WRL_N = ~wl; WRU_N = ~wu;
    @(negedge CLK);
    CS_N = 1'b1; WRL_N = 1'b1; WRU_N = 1'b1;
  endtask

  task automatic rd_ack(input logic [15:0] off);
    @(negedge CLK);
    A = {10'h189, off[15:1]}; CS_N = 1'b0; RD_N = 1'b0;
    @(negedge CLK);
    CS_N = 1'b1; RD_N = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;

    repeat (3) @(negedge CLK);
    RST = 1'b0;

    chk_reg("rst_cr1", CR1, 16'h0043);
    chk_reg("rst_cr2", CR2, 16'h4442);
    chk_reg("rst_cr3", CR3, 16'h4C4F);
    chk_reg("rst_cr4", CR4, 16'h434B);
    chk_reg("rst_hirq", HIRQ, 16'h0001);
    chk_reg("rst_mask", MASK, 16'h0000);
    chk("rst_irq_n", 16'(IRQ_N), 16'h0001);
    chk("rst_busy", 16'(BUSY), 16'h0000);
    chk_reg("unmapped_00", 16'h0000, 16'h0000);
    chk_reg("unmapped_3c", 16'h003C, 16'h0000);
    A = {10'h188, 15'h000C}; CS_N = 1'b0; RD_N = 1'b0;
    #1 chk("wrong_page", DO, 16'h0000);
    CS_N = 1'b1;
    A = {10'h189, 15'h000C};
    #1 chk("deselected", DO, 16'h0000);
    RD_N = 1'b1;

    CE_R = 1'b0;
    wr(CR1, 16'h1234);
    CE_R = 1'b1;
    chk_reg("ce_low_write", CR1, 16'h0043);

    // GetHwInfo
    wr(CR1, 16'h0100); wr(CR2, 16'h0000); wr(CR3, 16'h0000); wr(CR4, 16'h0000);
    chk_reg("hw_cmok_clr", HIRQ, 16'h0000);
    chk("hw_busy", 16'(BUSY), 16'h0001);
    tick(CMD_LAT);
    chk("hw_busy_late", 16'(BUSY), 16'h0001);
    chk_reg("hw_cmok_late", HIRQ, 16'h0000);
    tick(1);
    chk_reg("hw_cr1", CR1, 16'h0100);
    chk_reg("hw_cr2", CR2, 16'h0201);
    chk_reg("hw_cr3", CR3, 16'h0000);
    chk_reg("hw_cr4", CR4, 16'h0400);
    chk_reg("hw_cmok", HIRQ, 16'h0001);
    chk("hw_busy_done", 16'(BUSY), 16'h0000);
    chk("hw_irq_unmasked", 16'(IRQ_N), 16'h0001);

    // Interrupt mask and byte lanes
    wr(MASK, 16'h0001);
    chk("mask_irq_delay", 16'(IRQ_N), 16'h0001);
    tick(1);
    chk("mask_irq_low", 16'(IRQ_N), 16'h0000);
    wr(MASK, 16'hABCD, 1'b0, 1'b1);
    chk_reg("mask_hi_byte", MASK, 16'hAB01);
    wr(MASK, 16'h55FF, 1'b1, 1'b0);
    chk_reg("mask_lo_byte", MASK, 16'hABFF);
    wr(MASK, 16'h0001);
    wr(HIRQ, 16'h0000, 1'b0, 1'b1);
    chk_reg("hirq_hi_only", HIRQ, 16'h0001);
    wr(HIRQ, 16'hFFFE);
    chk_reg("hirq_clear", HIRQ, 16'h0000);
    chk("hirq_irq_delay", 16'(IRQ_N), 16'h0000);
    tick(1);
    chk("hirq_irq_high", 16'(IRQ_N), 16'h0001);

    // GetStatus with interrupt timing
    wr(CR1, 16'h0000); wr(CR2, 16'hAAAA); wr(CR3, 16'h5555); wr(CR4, 16'h1234);
    tick(CMD_LAT);
    chk_reg("gs_cmok_late", HIRQ, 16'h0000);
    tick(1);
    chk_reg("gs_cmok", HIRQ, 16'h0001);
    chk_reg("gs_cr1", CR1, 16'h0100);
    chk_reg("gs_cr2", CR2, 16'h0000);
    chk_reg("gs_cr4", CR4, 16'h0000);
    chk("gs_irq_delay", 16'(IRQ_N), 16'h0001);
    tick(1);
    chk("gs_irq_low", 16'(IRQ_N), 16'h0000);
    wr(HIRQ, 16'hFFFE);
    tick(1);

    // Reject opcode; writes while busy are ignored and latency is not restarted
    wr(CR1, 16'h5500); wr(CR2, 16'h1111); wr(CR3, 16'h2222); wr(CR4, 16'h3333);
    wr(CR4, 16'h9999);
    wr(CR2, 16'h7777);
    chk_reg("busy_cr2_ign", CR2, 16'h1111);
    chk_reg("busy_cr4_ign", CR4, 16'h3333);
    chk("rej_busy", 16'(BUSY), 16'h0001);
    tick(1);
    chk_reg("rej_cr1", CR1, 16'hFF00);
    chk_reg("rej_cr2", CR2, 16'h0000);
    chk_reg("rej_cr3", CR3, 16'h0000);
    chk_reg("rej_cr4", CR4, 16'h0000);
    chk_reg("rej_cmok", HIRQ, 16'h0001);
    chk("rej_busy_done", 16'(BUSY), 16'h0000);

    // Periodic report held off until the response is read
    tick(3 * PERIOD);
    chk_reg("pend_cr1", CR1, 16'hFF00);
    chk_reg("pend_cr4", CR4, 16'h0000);
    rd_ack(CR4);
    tick(PERIOD);
    chk_reg("report_cr1", CR1, 16'h2100);
    chk_reg("report_cr2", CR2, 16'h0000);
    chk_reg("report_cr3", CR3, 16'h0000);
    chk_reg("report_cr4", CR4, 16'h0000);

    // Reset during a command
    wr(CR1, 16'h0100); wr(CR2, 16'h0000); wr(CR3, 16'h0000); wr(CR4, 16'h0000);
    chk("mid_busy", 16'(BUSY), 16'h0001);
    tick(2);
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    chk_reg("rr_cr1", CR1, 16'h0043);
    chk_reg("rr_cr2", CR2, 16'h4442);
    chk_reg("rr_cr3", CR3, 16'h4C4F);
    chk_reg("rr_cr4", CR4, 16'h434B);
    chk_reg("rr_hirq", HIRQ, 16'h0001);
    chk_reg("rr_mask", MASK, 16'h0000);
    chk("rr_busy", 16'(BUSY), 16'h0000);
    chk("rr_irq_n", 16'(IRQ_N), 16'h0001);
    tick(10);
    chk_reg("rr_no_resp_cr1", CR1, 16'h0043);
    chk_reg("rr_no_resp_cr2", CR2, 16'h4442);
    chk("rr_no_resp_busy", 16'(BUSY), 16'h0000);
    peek(HIRQ, d);
    chk("rr_no_resp_hirq", d, 16'h0001);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
